pwm_dac: RTL and testbench

PWM_DAC -- requirements
Module: pwm_dac

---
 rtl/pwm_dac.sv | 66 ++++++
 tb/tb_pwm_dac.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_dac.sv
// PWM DAC: plays one latched sample code per window of CYCLES_PER_WINDOW clocks.
// Optional build macro PWM_DAC_OFFSET_BINARY_EN treats code as two's complement.
module pwm_dac #(
  parameter int CYCLES_PER_WINDOW = 1024,
  parameter int CODE_WIDTH        = $clog2(CYCLES_PER_WINDOW)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [CODE_WIDTH-1:0] code,
  output logic                  next_sample,
  output logic                  pwm
);

  localparam logic [CODE_WIDTH-1:0] LAST     = CODE_WIDTH'(CYCLES_PER_WINDOW - 1);
  localparam logic [CODE_WIDTH-1:0] MSB_MASK = CODE_WIDTH'(1) << (CODE_WIDTH - 1);

  if (CYCLES_PER_WINDOW < 4 || (CYCLES_PER_WINDOW & (CYCLES_PER_WINDOW - 1)) != 0)
    $error("pwm_dac: CYCLES_PER_WINDOW must be a power of two and at least 4");
  if (CODE_WIDTH != $clog2(CYCLES_PER_WINDOW))
    $error("pwm_dac: CODE_WIDTH must equal clog2(CYCLES_PER_WINDOW)");

  logic [CODE_WIDTH-1:0] cnt, cnt_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [CODE_WIDTH-1:0] code_xf;
  logic                  wrap;
  logic                  pwm_d;

`ifdef PWM_DAC_OFFSET_BINARY_EN
  // Two's complement to offset binary: flipping the MSB maps most-negative to 0.
  assign code_xf = code ^ MSB_MASK;
`else
  assign code_xf = code;
`endif

  // Reset holds cnt at 0, so no pulse can escape while rst is high.
  assign wrap        = en && (cnt == LAST);
  assign next_sample = wrap;

  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    cnt_d  = '0;
    code_d = code_q;
    pwm_d  = 1'b0;
    if (en) begin
      cnt_d = wrap ? '0 : cnt + 1'b1;
      if (wrap) code_d = code_xf;
      // Compare against the post-edge count and code so pwm lines up with cnt.
      pwm_d = (cnt_d < code_d);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, avoiding read/write races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      code_q <= '0;
      pwm    <= 1'b0;
    end else begin
      cnt    <= cnt_d;
      code_q <= code_d;
      pwm    <= pwm_d;
    end
  end

endmodule

// File: tb/tb_pwm_dac.sv
// Self-checking bench for pwm_dac (N=8): directed scenarios plus random en/code/rst
// compared against a window-level reference model.
module tb_pwm_dac;

  localparam int N  = 8;
  localparam int CW = $clog2(N);

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [CW-1:0] code;
  logic          next_sample;
  logic          pwm;

  pwm_dac #(.CYCLES_PER_WINDOW(N), .CODE_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .code        (code),
    .next_sample (next_sample),
    .pwm         (pwm)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position in window, code being played, expected pwm.
  int m_pos;
  int m_play;
  bit m_pwm;

  int win_hi;
  int cyc;
  int ns_q[$];

  function automatic int duty_of(input int c);
`ifdef PWM_DAC_OFFSET_BINARY_EN
    return (c + N / 2) % N;
`else
    return c;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pos  = 0;
    m_play = 0;
    m_pwm  = 1'b0;
  endtask

  // Checks the current cycle at negedge, then advances the model across the posedge.
  task automatic tick();
    @(negedge clk);
    check("pwm", pwm, m_pwm);
    check("next_sample", next_sample, (!rst && en && m_pos == N - 1));
    if (pwm === 1'b1) win_hi++;
    if (next_sample === 1'b1) ns_q.push_back(cyc);
    cyc++;
    @(posedge clk);
    if (rst) model_reset();
    else if (!en) begin
      m_pos = 0;
      m_pwm = 1'b0;
    end else begin
      if (m_pos == N - 1) m_play = duty_of(code);
      m_pos = (m_pos + 1) % N;
      m_pwm = (m_pos < m_play);
    end
    #1;
  endtask

  task automatic run_window(input int exp_hi, input string tag);
    win_hi = 0;
    repeat (N) tick();
    check(tag, win_hi, exp_hi);
  endtask

  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    code = CW'(3);
    model_reset();
    cyc = 0;
    repeat (3) tick();

    // Scenario A: code held at 3 from reset release.
    rst = 1'b0;
    en  = 1'b1;
    cyc = 0;
    ns_q.delete();
    run_window(0, "A_win0_hi");
    run_window(duty_of(3), "A_win1_hi");
    run_window(duty_of(3), "A_win2_hi");
    check("A_ns_count", ns_q.size(), 3);
    if (ns_q.size() == 3) begin
      check("A_ns_first", ns_q[0], 7);
      check("A_ns_second", ns_q[1], 15);
      check("A_ns_third", ns_q[2], 23);
    end

    // Scenario B: code 0 then code 7, each playing one window after it is loaded.
    code = CW'(0);
    run_window(duty_of(3), "B_pre_hi");
    code = CW'(7);
    run_window(duty_of(0), "B_zero_hi");
    code = CW'(3);
    run_window(duty_of(7), "B_seven_hi");

    // Scenario C: mid-window code change does not disturb the window in flight.
    win_hi = 0;
    repeat (2) tick();
    code = CW'(6);
    repeat (N - 2) tick();
    check("C_cur_hi", win_hi, duty_of(3));
    run_window(duty_of(6), "C_next_hi");

    // Scenario D: disable at cnt=4 for 5 cycles, then re-enable.
    repeat (4) tick();
    en   = 1'b0;
    code = CW'(1);
    ns_q.delete();
    tick();
    win_hi = 0;
    repeat (4) tick();
    check("D_off_pwm_hi", win_hi, 0);
    check("D_off_ns", ns_q.size(), 0);
    en  = 1'b1;
    cyc = 0;
    ns_q.delete();
    repeat (N) tick();
    check("D_ns_count", ns_q.size(), 1);
    if (ns_q.size() == 1) check("D_ns_at", ns_q[0], 7);

    // Scenario E: reset pulsed at cnt=6 abandons the window.
    code = CW'(5);
    repeat (6) tick();
    rst = 1'b1;
    model_reset();
    #1;
    check("E_pwm_async", pwm, 1'b0);
    check("E_ns_async", next_sample, 1'b0);
    ns_q.delete();
    repeat (2) tick();
    check("E_ns_in_rst", ns_q.size(), 0);
    rst = 1'b0;
    cyc = 0;
    ns_q.delete();
    run_window(0, "E_first_hi");
    check("E_ns_count", ns_q.size(), 1);
    if (ns_q.size() == 1) check("E_ns_at", ns_q[0], 7);
    run_window(duty_of(5), "E_second_hi");

`ifdef PWM_DAC_OFFSET_BINARY_EN
    // Scenario F: offset-binary mapping of 0, most negative and most positive.
    code = CW'(0);
    run_window(duty_of(5), "F_pre_hi");
    code = CW'(4);
    run_window(4, "F_zero_hi");
    code = CW'(3);
    run_window(0, "F_neg_hi");
    run_window(7, "F_pos_hi");
`endif

    // Random phase: en, code and asynchronous reset at arbitrary positions.
    for (int i = 0; i < 800; i++) begin
      code = CW'($urandom_range(0, N - 1));
      en   = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 59) == 0) begin
        rst = 1'b1;
        model_reset();
      end else begin
        rst = 1'b0;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
